// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator block: op codes, FSM states, default width.
package acc_pkg;

    localparam int DEFAULT_W = 8;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/acc_addsub.sv
// Combinational W-bit adder/subtractor; cout is carry for add, borrow for subtract.
module acc_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] result,
    output logic         cout
);

    logic [W:0] full;

    // Zero-extending both operands makes bit W the carry on add and the borrow on subtract.
    always_comb begin
        if (sub) full = {1'b0, a} - {1'b0, b};
        else     full = {1'b0, a} + {1'b0, b};
    end

    assign result = full[W-1:0];
    assign cout   = full[W];

endmodule

// File: rtl/acc_unit.sv
// Accumulator with in-place arithmetic, status flags, tri-state bus driver and
// an iterative shift-add unsigned multiplier whose high half lands in x.
module acc_unit
    import acc_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] i,
    input  logic [2:0]   op,
    input  logic         op_valid,
    input  logic         ea,
    output logic [W-1:0] bus,
    output logic [W-1:0] s,
    output logic [W-1:0] x,
    output logic         busy,
    output logic         done,
    output logic         cf,
    output logic         zf,
    output logic         nf
);

    localparam int CW = $clog2(W + 1);

    state_t         state, state_n;
    logic [W-1:0]   acc, acc_n, x_n, m, m_n;
    logic [CW-1:0]  count, count_n;
    logic           cf_n, zf_n, nf_n, done_n, write;

    logic [W-1:0]   add_a, add_b, sum;
    logic           add_sub, cout;

    // One adder serves ADD/SUB in IDLE and the partial-product add while multiplying.
    assign add_a   = (state == MUL) ? x : acc;
    assign add_b   = (state == MUL) ? (acc[0] ? m : '0) : i;
    assign add_sub = (state == IDLE) && (op == OP_SUB);

    acc_addsub #(.W(W)) u_addsub (
        .a      (add_a),
        .b      (add_b),
        .sub    (add_sub),
        .result (sum),
        .cout   (cout)
    );

    always_comb begin
        state_n = state;
        acc_n   = acc;
        x_n     = x;
        m_n     = m;
        count_n = count;
        cf_n    = cf;
        zf_n    = zf;
        nf_n    = nf;
        done_n  = 1'b0;
        write   = 1'b0;

        if (state == IDLE) begin
            if (op_valid) begin
                case (op)
                    OP_LOAD: begin acc_n = i;   cf_n = 1'b0; write = 1'b1; done_n = 1'b1; end
                    OP_ADD,
                    OP_SUB:  begin acc_n = sum; cf_n = cout; write = 1'b1; done_n = 1'b1; end
                    OP_SHL: begin
                        acc_n  = {acc[W-2:0], 1'b0};
                        cf_n   = acc[W-1];
                        write  = 1'b1;
                        done_n = 1'b1;
                    end
                    OP_SHR: begin
                        acc_n  = {1'b0, acc[W-1:1]};
                        cf_n   = acc[0];
                        write  = 1'b1;
                        done_n = 1'b1;
                    end
                    OP_CLR: begin
                        acc_n  = '0;
                        x_n    = '0;
                        cf_n   = 1'b0;
                        write  = 1'b1;
                        done_n = 1'b1;
                    end
                    OP_MUL: begin
                        if (MUL_EN != 0) begin
                            m_n     = i;
                            x_n     = '0;
                            count_n = '0;
                            state_n = MUL;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            // {x,acc} shifts right one bit per step, pulling the add carry into x's MSB.
            x_n     = {cout, sum[W-1:1]};
            acc_n   = {sum[0], acc[W-1:1]};
            count_n = count + 1'b1;
            if (count == CW'(W - 1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
                cf_n    = (x_n != '0);
                zf_n    = (acc_n == '0) && (x_n == '0);
                nf_n    = acc_n[W-1];
            end
        end

        if (write) begin
            zf_n = (acc_n == '0);
            nf_n = acc_n[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
            acc   <= '0;
            x     <= '0;
            m     <= '0;
            count <= '0;
            cf    <= 1'b0;
            zf    <= 1'b0;
            nf    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            x     <= x_n;
            m     <= m_n;
            count <= count_n;
            cf    <= cf_n;
            zf    <= zf_n;
            nf    <= nf_n;
            done  <= done_n;
        end
    end

    assign busy = (state == MUL);
    assign s    = acc;
    assign bus  = ea ? acc : {W{1'bz}};

endmodule
